mult_seq_control: RTL

//  Sequencer for the signed shift-add multiplier built around the AddSub / carry-select adder.

---
 rtl/mult_seq_control_if.sv | 28 ++
 rtl/mult_seq_control.sv | 119 +++++++++++
 2 files changed

// File: rtl/mult_seq_control_if.sv
// Signal bundle between the shift-add multiplier sequencer and its surroundings
// (switch/button inputs, AddSub adder, hex-display drivers).
interface mult_seq_control_if #(
    parameter int WIDTH = 8
);
    logic             Run;
    logic             ClearA_LoadB;
    logic [WIDTH-1:0] Sw;
    logic [WIDTH-1:0] Ans_in;
    logic             X_in;
    logic             Add;
    logic             Sub;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic [WIDTH-1:0] Mval;
    logic             Xval;
    logic             Done;

    modport master (
        output Run, ClearA_LoadB, Sw, Ans_in, X_in,
        input  Add, Sub, Aval, Bval, Mval, Xval, Done
    );

    modport slave (
        input  Run, ClearA_LoadB, Sw, Ans_in, X_in,
        output Add, Sub, Aval, Bval, Mval, Xval, Done
    );
endinterface

// File: rtl/mult_seq_control.sv
// Sequencer for a signed WIDTH x WIDTH shift-add multiplier; product lands in {A,B}, sign in X.
// Optional MULT_SEQ_SKIP_EN: bypass the ADD state for multiplier bits that are zero.
module mult_seq_control #(
    parameter int WIDTH = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    mult_seq_control_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic             x_reg;
    logic             add;
    logic             sub;
    logic             done;
    logic             last_bit;

    assign last_bit = (cnt == 4'(WIDTH - 1));

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        add        = 1'b0;
        sub        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Run) state_next = CLR;
            end
            CLR: begin
`ifdef MULT_SEQ_SKIP_EN
                state_next = b_reg[0] ? ADD : SHIFT;
`else
                state_next = ADD;
`endif
            end
            ADD: begin
                state_next = SHIFT;
                // The top multiplier bit carries negative weight, so its partial product is subtracted.
                if (b_reg[0]) begin
                    if (last_bit) sub = 1'b1;
                    else          add = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end else begin
`ifdef MULT_SEQ_SKIP_EN
                    state_next = b_reg[1] ? ADD : SHIFT;
`else
                    state_next = ADD;
`endif
                end
            end
            DONE: begin
                done = 1'b1;
                if (!bus.Run) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            x_reg <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        m_reg <= bus.Sw;
                    end else if (bus.ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= bus.Sw;
                    end
                end
                CLR: begin
                    a_reg <= '0;
                    x_reg <= 1'b0;
                    cnt   <= '0;
                end
                ADD: begin
                    if (b_reg[0]) begin
                        a_reg <= bus.Ans_in;
                        x_reg <= bus.X_in;
                    end
                end
                SHIFT: begin
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    if (!last_bit) cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Add  = add;
    assign bus.Sub  = sub;
    assign bus.Done = done;
    assign bus.Aval = a_reg;
    assign bus.Bval = b_reg;
    assign bus.Mval = m_reg;
    assign bus.Xval = x_reg;
endmodule
